mux_arb_n: RTL

MUX_ARB_N -- requirements
Module: mux_arb_n

---
 rtl/mux_arb_pkg.sv | 22 ++
 rtl/mux_arb_n_arbiter.sv | 53 +++++
 rtl/mux_arb_n.sv | 79 +++++++
 3 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the N-channel arbitrating mux.
// Holds the selection-mode enum, default sizes and a pointer helper.
package mux_arb_pkg;

    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mode_e;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_N_CH  = 4;
    localparam int CNT_W     = 16;

    // Increment modulo n without relying on n being a power of two.
    function automatic int wrap_inc(
        input int v,
        input int n
    );
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/mux_arb_n_arbiter.sv
// Combinational grant logic for mux_arb_n (module rr_arbiter).
// Ports: req (per-channel request), rr_ptr (round-robin start),
//   mode, sel (external index) -> grant (one-hot), grant_idx,
//   grant_valid. Holds no state.
module rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int N_CH = DEF_N_CH,
    parameter int IW   = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    input  mode_e           mode,
    input  logic [IW-1:0]   sel,
    output logic [N_CH-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            grant_valid
);

    int c;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        c           = 0;
        unique case (1'b1)
            (mode == MODE_SEL): begin
                // Indices past the last channel never grant.
                if (int'(sel) < N_CH) begin
                    if (req[sel]) begin
                        grant_valid = 1'b1;
                        grant_idx   = sel;
                    end
                end
            end
            (mode == MODE_RR): begin
                // Scan from rr_ptr upward, wrapping; first hit wins.
                for (int k = 0; k < N_CH; k++) begin
                    c = (int'(rr_ptr) + k) % N_CH;
                    if (!grant_valid && req[c]) begin
                        grant_valid = 1'b1;
                        grant_idx   = IW'(c);
                    end
                end
            end
        endcase
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/mux_arb_n.sv
// N-channel arbitrating mux with a single registered output stage.
// Ports: clk, reset (async, active-high); in_valid/in_data/in_ready
//   per channel; sel (MODE_SEL index); out_valid/out_data/out_ch/
//   out_ready output handshake; xfer_cnt counts output transfers.
module mux_arb_n
    import mux_arb_pkg::*;
#(
    parameter int    WIDTH = DEF_WIDTH,
    parameter int    N_CH  = DEF_N_CH,
    parameter mode_e MODE  = MODE_RR
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_CH-1:0]        in_valid,
    input  logic [WIDTH-1:0]       in_data [N_CH],
    output logic [N_CH-1:0]        in_ready,
    input  logic [$clog2(N_CH)-1:0] sel,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [$clog2(N_CH)-1:0] out_ch,
    input  logic                   out_ready,
    output logic [CNT_W-1:0]       xfer_cnt
);

    localparam int IW = $clog2(N_CH);

    logic [N_CH-1:0] grant;
    logic [IW-1:0]   grant_idx;
    logic            grant_valid;
    logic [IW-1:0]   rr_ptr;
    logic            load_en;
    logic            drain;

    rr_arbiter #(
        .N_CH (N_CH),
        .IW   (IW)
    ) u_arb (
        .req         (in_valid),
        .rr_ptr      (rr_ptr),
        .mode        (MODE),
        .sel         (sel),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // The stage can take a word when empty or draining this edge.
    assign drain   = out_valid && out_ready;
    assign load_en = (!out_valid || out_ready) && grant_valid;

    // No accepts are advertised while reset holds the stage clear.
    assign in_ready = (load_en && !reset) ? grant : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            xfer_cnt  <= '0;
            rr_ptr    <= '0;
        end else begin
            if (load_en) begin
                out_valid <= 1'b1;
                out_data  <= in_data[grant_idx];
                out_ch    <= grant_idx;
            end else if (drain) begin
                out_valid <= 1'b0;
            end
            if (drain) begin
                xfer_cnt <= xfer_cnt + 1'b1;
            end
            // External-select mode never moves the pointer.
            if (MODE == MODE_RR && load_en) begin
                rr_ptr <= IW'(wrap_inc(int'(grant_idx), N_CH));
            end
        end
    end

endmodule
